// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit; shift-add multiply and restoring divide, UNROLL bits per cycle.
// Latency N+2 cycles (N=XLEN/UNROLL); special divides, and early-outs under RISCV_MULDIV_EARLY_OUT_EN, finish in 2.
// Backpressure: none; start_i is ignored while busy_o/done_o, and flush_i aborts the op in flight.
module riscv_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(N - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              sa_q, sb_q, fast_q;
    logic [XLEN-1:0]   mag_q, rem_q, fast_res_q;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     count;

    // Operand decode, only meaningful while IDLE
    logic            signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf, special, fast_in;
    logic [XLEN-1:0] a_mag, b_mag, special_res, fast_val;

    always_comb begin
        signed_a    = (op_i != 3'b011) && !(op_i[2] && op_i[0]);
        signed_b    = signed_a && (op_i != 3'b010);
        a_neg       = signed_a && a_i[XLEN-1];
        b_neg       = signed_b && b_i[XLEN-1];
        a_mag       = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag       = b_neg ? (~b_i + 1'b1) : b_i;
        div_zero    = op_i[2] && (b_i == '0);
        div_ovf     = op_i[2] && !op_i[0] && (a_i == MOST_NEG) && (b_i == '1);
        special     = div_zero || div_ovf;
        special_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
`ifdef RISCV_MULDIV_EARLY_OUT_EN
        fast_in  = special || (!op_i[2] && (a_i == '0 || b_i == '0)) || (op_i[2] && (a_mag < b_mag));
        fast_val = special ? special_res : ((op_i[2] && op_i[1]) ? a_i : '0);
`else
        fast_in  = special;
        fast_val = special_res;
`endif
    end

    // One CALC cycle: acc holds {hi,lo}; divide keeps the quotient in lo and the partial remainder in rem_q
    logic [XLEN-1:0] hi_n, lo_n, rem_n;
    logic [XLEN:0]   sum, trial;

    always_comb begin
        hi_n  = acc[2*XLEN-1:XLEN];
        lo_n  = acc[XLEN-1:0];
        rem_n = rem_q;
        sum   = '0;
        trial = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (!op_q[2]) begin
                sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, mag_q} : '0);
                hi_n = sum[XLEN:1];
                lo_n = {sum[0], lo_n[XLEN-1:1]};
            end else begin
                trial = {rem_n, lo_n[XLEN-1]};
                lo_n  = {lo_n[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, mag_q}) begin
                    trial   = trial - {1'b0, mag_q};
                    lo_n[0] = 1'b1;
                end
                rem_n = trial[XLEN-1:0];
            end
        end
    end

    // Sign correction and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_res;

    always_comb begin
        prod = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
        quo  = (sa_q ^ sb_q) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rmd  = sa_q ? (~rem_q + 1'b1) : rem_q;
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rmd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            fast_q     <= 1'b0;
            mag_q      <= '0;
            rem_q      <= '0;
            fast_res_q <= '0;
            acc        <= '0;
            count      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op_q       <= op_i;
                        sa_q       <= a_neg;
                        sb_q       <= b_neg;
                        // Multiply adds |a| per set bit of |b|; divide subtracts |b| from |a|
                        mag_q      <= op_i[2] ? b_mag : a_mag;
                        acc        <= {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
                        rem_q      <= '0;
                        count      <= CNT_INIT;
                        fast_q     <= fast_in;
                        fast_res_q <= fast_val;
                        busy_o     <= 1'b1;
                        state      <= fast_in ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc   <= {hi_n, lo_n};
                    rem_q <= rem_n;
                    if (count == '0) state <= FIX;
                    else             count <= count - 1'b1;
                end
                FIX: begin
                    result_o <= fast_q ? fast_res_q : fix_res;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: directed vectors, randomized ops against an arithmetic model,
// mid-op flush/reset/start disturbances, and an XLEN=64/UNROLL=4 instance.
module tb_riscv_muldiv_unit;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, result;
    logic        busy, done;

    logic        start64 = 1'b0, flush64 = 1'b0;
    logic [2:0]  op64 = '0;
    logic [63:0] a64 = '0, b64 = '0, result64;
    logic        busy64, done64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .flush_i(flush), .busy_o(busy), .done_o(done), .result_o(result)
    );

    riscv_muldiv_unit #(.XLEN(64), .UNROLL(4)) dut64 (
        .clk(clk), .rst(rst), .start_i(start64), .op_i(op64), .a_i(a64), .b_i(b64),
        .flush_i(flush64), .busy_o(busy64), .done_o(done64), .result_o(result64)
    );

    // Reference model straight from the RISC-V M-extension definitions
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        logic [63:0]        pu;
        case (o)
            OP_MUL:    return x * y;
            OP_MULH:   begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return p[63:32]; end
            OP_MULHSU: begin p = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return p[63:32]; end
            OP_MULHU:  begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            OP_DIV:    if (y == 0) return '1; else if (x == MIN32 && y == '1) return x;
                       else return $signed(x) / $signed(y);
            OP_DIVU:   if (y == 0) return '1; else return x / y;
            OP_REM:    if (y == 0) return x; else if (x == MIN32 && y == '1) return 0;
                       else return $signed(x) % $signed(y);
            default:   if (y == 0) return x; else return x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic sgn;
        logic [31:0] mx, my;
        sgn = (o == OP_DIV) || (o == OP_REM);
        mx = (sgn && x[31]) ? -x : x;
        my = (sgn && y[31]) ? -y : y;
        if (o[2] && y == 0) return 2;
        if (sgn && x == MIN32 && y == '1) return 2;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
        if (!o[2] && (x == 0 || y == 0)) return 2;
        if (o[2] && mx < my) return 2;
`else
        if (mx == my && mx == 32'hFFFF_FFFF) return 34;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN32;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Launch one op; returns in cycle T+1 with the operand inputs scrambled
    task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // Cycle index (T+lat) at which done is seen; -1 on timeout
    task automatic wait_done(output logic [31:0] res, output int lat);
        lat = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            lat++;
            if (lat > 200) begin lat = -1; break; end
        end
        res = result;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
        n_tests++; if (result64 !== 64'd0) begin n_fail++; $display("FAIL reset_result64 got=%h want=0", result64); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                                  OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [31:0] as  [12] = '{32'd7, MIN32, MIN32, 32'hFFFF_FFFF, -32'd7, -32'd7,
                                  32'd100, 32'd100, 32'd5, 32'd5, MIN32, MIN32};
        logic [31:0] bs  [12] = '{-32'd3, MIN32, MIN32, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, MIN32, 32'd0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 12; i++) begin
            start_op(ops[i], as[i], bs[i]);
            wait_done(res, lat);
            n_tests++;
            if (res !== exp[i]) begin n_fail++; $display("FAIL directed_%0d_result got=%h want=%h", i, res, exp[i]); end
            n_tests++;
            if (lat != exp_lat(ops[i], as[i], bs[i])) begin
                n_fail++; $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, exp_lat(ops[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_busy();
        int bad_busy = 0, bad_done = 0;
        start_op(OP_MUL, 32'd7, -32'd3);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (busy !== (c <= 33)) bad_busy++;
            if (done !== (c == 34)) bad_done++;
        end
        n_tests++; if (bad_busy != 0) begin n_fail++; $display("FAIL busy_window bad_cycles=%0d want=0", bad_busy); end
        n_tests++; if (bad_done != 0) begin n_fail++; $display("FAIL done_pulse bad_cycles=%0d want=0", bad_done); end
        n_tests++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL busy_result got=%h want=ffffffeb", result); end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y, res;
        int lat;
        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7)); x = rnd32(); y = rnd32();
            start_op(o, x, y);
            wait_done(res, lat);
            n_tests++;
            if (res !== model(o, x, y)) begin
                n_fail++; $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", o, x, y, res, model(o, x, y));
            end
            n_tests++;
            if (lat != exp_lat(o, x, y)) begin
                n_fail++; $display("FAIL random_latency op=%0d a=%h b=%h got=%0d want=%0d", o, x, y, lat, exp_lat(o, x, y));
            end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || result !== model(o, x, y)) begin
                n_fail++; $display("FAIL random_hold done=%b result=%h want done=0 result=%h", done, result, model(o, x, y));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, extra = 0;
        start_op(OP_DIVU, 32'd1000, 32'd7);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(res, lat);
        n_tests++; if (res !== 32'd142) begin n_fail++; $display("FAIL b2b_result got=%h want=%h", res, 32'd142); end
        // start raised only during DONE must be dropped
        start = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL start_in_done_ignored active_cycles=%0d want=0", extra); end
        n_tests++; if (result !== 32'd142) begin n_fail++; $display("FAIL start_in_done_result got=%h want=%h", result, 32'd142); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, extra = 0;
        start_op(OP_DIVU, 32'd100, 32'd7);
        wait_done(res, lat);
        start_op(OP_MUL, 32'd12345, 32'd678);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b want=0", busy); end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL flush_no_done active_cycles=%0d want=0", extra); end
        n_tests++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result_kept got=%h want=%h", result, 32'd14); end
        start_op(OP_REMU, 32'd100, 32'd7);
        wait_done(res, lat);
        n_tests++;
        if (res !== 32'd2 || lat != 34) begin
            n_fail++; $display("FAIL flush_recover got=%h lat=%0d want=%h lat=34", res, lat, 32'd2);
        end
    endtask

    task automatic test_flush_start_idle();
        int extra = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL flush_beats_start active_cycles=%0d want=0", extra); end
        n_tests++; if (result !== 32'd2) begin n_fail++; $display("FAIL flush_beats_start_result got=%h want=%h", result, 32'd2); end
    endtask

    task automatic test_reset_midop();
        int extra = 0;
        start_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_fail++; $display("FAIL reset_midop busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL reset_midop_no_done active_cycles=%0d want=0", extra); end
    endtask

    task automatic test_unroll64();
        logic [2:0]   o;
        logic [63:0]  x, y, want;
        logic [127:0] p;
        int lat, wlat;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin o = OP_MUL; x = 64'h1_0000_0001; y = 64'd3; end
            else begin
                o = (i % 2 == 0) ? OP_MUL : OP_MULHU;
                x = (i == 1) ? 64'd0 : {$urandom, $urandom};
                y = {$urandom, $urandom};
            end
            p = {64'd0, x} * {64'd0, y};
            want = (o == OP_MUL) ? p[63:0] : p[127:64];
            wlat = 18;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
            if (x == 0 || y == 0) wlat = 2;
`endif
            @(negedge clk);
            start64 = 1'b1; op64 = o; a64 = x; b64 = y;
            @(posedge clk);
            #1;
            start64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            lat = 1;
            forever begin
                @(negedge clk);
                if (done64) break;
                lat++;
                if (lat > 100) begin lat = -1; break; end
            end
            n_tests++;
            if (result64 !== want || lat != wlat) begin
                n_fail++; $display("FAIL unroll64 op=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                                   o, x, y, result64, lat, want, wlat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy();
        test_random();
        test_back_to_back();
        test_flush();
        test_flush_start_idle();
        test_reset_midop();
        test_unroll64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
